sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-requester arbiter that shares the single-port 16K-word data SRAM between an instruction-fetch master (port 0) and a load/store master (port 1). It drives the SRAM's address, write-enable and write-data inputs, one access per cycle. Priority is round-robin with a bounded burst: a master may keep ownership for up to MAX_BURST consecutive beats while the other master waits. Read data is returned through a registered response.

## Interface
- ADDR_W, 14, word address width (16K words)
- DATA_W, 32, data width
- MAX_BURST, 4, maximum consecutive beats granted to one owner while the other requests (≥1)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- req0 / req1  in  1  access request, port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  word address
- wd0 / wd1  in  DATA_W  write data
- gnt0 / gnt1  out  1  combinational; beat accepted at this rising edge
- rvalid0 / rvalid1  out  1  registered; read data valid (one-cycle pulse)
- rdata0 / rdata1  out  DATA_W  registered read data
- mem_addr  out  ADDR_W  to SRAM address
- mem_we  out  1  to SRAM write enable
- mem_wd  out  DATA_W  to SRAM write data
- mem_rd  in  DATA_W  from SRAM; combinational read of mem_addr

## Operation
- State: owner ∈ {IDLE, OWN0, OWN1}; last (index of last owner, 1 bit); cnt (beats granted to current owner, 0..MAX_BURST, saturating).
- Per-cycle decision (combinational from state and req):
  - Current owner requesting, and (cnt < MAX_BURST or other not requesting) → grant owner.
  - Otherwise, if the other master requests → grant other.
  - From IDLE or after owner drops req: if only one master requests, grant it; if both request, grant !last.
  - No request → no grant.
- At most one of gnt0/gnt1 is high. gnt is never high without the matching req.
- Mem outputs mux the granted port: mem_addr, mem_wd = granted port's values; mem_we = granted we. With no grant: mem_we = 0, mem_addr = addr0, mem_wd = 0.
- Register update on each edge with a grant to port p:
  - owner ← OWNp; last ← p.
  - If p matches the previous owner, cnt ← min(cnt+1, MAX_BURST); otherwise cnt ← 1.
  - Read beat: rdata_p ← mem_rd and rvalid_p ← 1.
  - Write beat: rvalid_p ← 0 and rdata_p holds its value.
- Any port not granted: rvalid ← 0, rdata holds.
- Edge with no grant: owner ← IDLE, cnt ← 0, last holds.
- Reset values (asynchronous): owner = IDLE, last = 1 (port 0 wins first tie), cnt = 0, rvalid0/1 = 0, rdata0/1 = 0. While reset is asserted, gnt0/1 = 0 and mem_we = 0. Reset mid-burst aborts the burst; no SRAM write occurs on edges during reset.

## Timing
- Write: SRAM updated at the edge where gnt&req&we is high; zero extra latency.
- Read: granted at edge N; rdata/rvalid valid in cycle N+1 (latency 1). Back-to-back reads give one result per cycle.
- Requester holds req/we/addr/wd stable until it sees gnt at an edge; the next beat may be presented the following cycle.
- Max wait for a requesting master while the other bursts: MAX_BURST cycles.
- Read then write to the same address in consecutive beats: the read returns the old data.

## Test plan
- Reset then single master: req0 read at addr 0x0005 (SRAM preloaded with 0x1111_FFFF) → gnt0 in the same cycle; next cycle rvalid0 = 1 and rdata0 = 0x1111_FFFF; gnt1 = 0 throughout.
- Tie after reset: req0 and req1 both asserted in the first cycle → gnt0 first; then, with both still requesting and MAX_BURST = 4, gnt0 for 4 beats, then gnt1 for 4 beats, alternating.
- Burst limit release: req1 alone for 10 beats → gnt1 on all 10 beats (cnt saturates, no stall). Raise req0 at beat 6 → gnt0 no later than beat 6 + MAX_BURST.
- Write/read through arbiter: port1 writes 0xABCD_1234 to 0x000C, then port0 reads 0x000C → rdata0 = 0xABCD_1234. A read followed next beat by a write of 0x4321_FFAA to the same address → the read returns the prior value.
- Reset mid-burst: assert reset during the OWN1 burst with we1 = 1 → gnt1 and mem_we drop immediately, rvalid = 0, memory unchanged. After release with both requesting → gnt0 first.
- Idle gap: requests drop for 1 cycle → owner IDLE and cnt 0. Next tie goes to !last.

Source files
------------

// File: rtl/sram_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one single-port SRAM between an
// instruction-fetch master (port 0) and a load/store master (port 1).
module sram_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wd0,
  input  logic [DATA_W-1:0] wd1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_t;

  owner_t           owner_r;
  logic             last_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             gnt0_s;
  logic             gnt1_s;
  logic             sel1_s;

  // Grant decision; only a tie needs the owner/burst/last state to resolve.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    sel1_s = 1'b0;
    if (reset) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (req0 && req1) begin
      case (owner_r)
        OWN0:    sel1_s = (cnt_r >= CNT_MAX);
        OWN1:    sel1_s = (cnt_r < CNT_MAX);
        IDLE:    sel1_s = ~last_r;
        default: sel1_s = ~last_r;
      endcase
      gnt0_s = ~sel1_s;
      gnt1_s = sel1_s;
    end else begin
      gnt0_s = req0;
      gnt1_s = req1;
    end
  end

  // Saturating beat count for an owner that keeps the grant.
  always_comb begin
    if (cnt_r >= CNT_MAX) begin
      cnt_inc_s = CNT_MAX;
    end else begin
      cnt_inc_s = cnt_r + CNT_ONE;
    end
  end

  assign gnt0     = gnt0_s;
  assign gnt1     = gnt1_s;
  assign mem_we   = (gnt0_s & we0) | (gnt1_s & we1);
  assign mem_addr = gnt1_s ? addr1 : addr0;
  assign mem_wd   = gnt0_s ? wd0 : (gnt1_s ? wd1 : {DATA_W{1'b0}});

  // Ownership, burst count and round-robin pointer; a grant-free edge idles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_r <= IDLE;
      last_r  <= 1'b1;
      cnt_r   <= CNT_ZERO;
    end else if (gnt0_s) begin
      owner_r <= OWN0;
      last_r  <= 1'b0;
      cnt_r   <= (owner_r == OWN0) ? cnt_inc_s : CNT_ONE;
    end else if (gnt1_s) begin
      owner_r <= OWN1;
      last_r  <= 1'b1;
      cnt_r   <= (owner_r == OWN1) ? cnt_inc_s : CNT_ONE;
    end else begin
      owner_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end
  end

  // Registered read responses; rdata holds across writes and idle cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= {DATA_W{1'b0}};
      rdata1  <= {DATA_W{1'b0}};
    end else begin
      rvalid0 <= gnt0_s & ~we0;
      rvalid1 <= gnt1_s & ~we1;
      if (gnt0_s && !we0) begin
        rdata0 <= mem_rd;
      end
      if (gnt1_s && !we1) begin
        rdata1 <= mem_rd;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus random traffic
// scored against a rule-level arbitration model and a shadow memory.
module tb_sram_arbiter;
  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;
  localparam int DEPTH     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              t_req  [2];
  logic              t_we   [2];
  logic [ADDR_W-1:0] t_addr [2];
  logic [DATA_W-1:0] t_wd   [2];
  logic              gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [DATA_W-1:0] rdata0, rdata1, mem_wd, mem_rd;
  logic [ADDR_W-1:0] mem_addr;

  logic [DATA_W-1:0] sram    [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic              mem_clr;

  int tests = 0;
  int fails = 0;
  int m_owner, m_last, m_cnt;
  logic              exp_rv [2];
  logic [DATA_W-1:0] exp_rd [2];
  int obs_g;
  int exp_g;

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .req0(t_req[0]), .req1(t_req[1]),
    .we0(t_we[0]), .we1(t_we[1]),
    .addr0(t_addr[0]), .addr1(t_addr[1]),
    .wd0(t_wd[0]), .wd1(t_wd[1]),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_word(input int a);
    return (a == 5) ? 32'h1111_FFFF : (32'h5A00_0000 ^ (a * 32'h0001_0003));
  endfunction

  // Behavioural single-port SRAM: combinational read, write on the clock edge.
  assign mem_rd = sram[mem_addr];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= init_word(i);
    end else if (mem_we) begin
      sram[mem_addr] <= mem_wd;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Who wins this cycle, stated directly from the arbitration rules.
  function automatic int pick(input logic r0, input logic r1);
    if (!r0 && !r1) return -1;
    if (r0 != r1) return r0 ? 0 : 1;
    if (m_owner < 0) return 1 - m_last;
    if (m_cnt < MAX_BURST) return m_owner;
    return 1 - m_owner;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_cnt   = 0;
    for (int p = 0; p < 2; p++) begin
      exp_rv[p] = 1'b0;
      exp_rd[p] = '0;
    end
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    t_req[p]  = r;
    t_we[p]   = w;
    t_addr[p] = a;
    t_wd[p]   = d;
  endtask

  // One clock: check combinational outputs at negedge, advance model at posedge,
  // check registered outputs 1 time unit later.
  task automatic cycle();
    int g;
    logic              we_g;
    logic [ADDR_W-1:0] addr_g;
    logic [DATA_W-1:0] wd_g;
    @(negedge clk);
    g = reset ? -1 : pick(t_req[0], t_req[1]);
    obs_g = gnt0 ? 0 : (gnt1 ? 1 : -1);
    we_g   = (g >= 0) ? t_we[g]   : 1'b0;
    addr_g = (g >= 0) ? t_addr[g] : t_addr[0];
    wd_g   = (g >= 0) ? t_wd[g]   : '0;
    check_eq("gnt0", gnt0, g == 0);
    check_eq("gnt1", gnt1, g == 1);
    check_eq("mem_we", mem_we, we_g);
    check_eq("mem_addr", mem_addr, addr_g);
    check_eq("mem_wd", mem_wd, wd_g);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      for (int p = 0; p < 2; p++) begin
        exp_rv[p] = (g == p) && !t_we[p];
        if (exp_rv[p]) exp_rd[p] = ref_mem[t_addr[p]];
      end
      if (g >= 0 && we_g) ref_mem[addr_g] = wd_g;
      if (g >= 0) begin
        m_cnt   = (g == m_owner) ? ((m_cnt < MAX_BURST) ? m_cnt + 1 : MAX_BURST) : 1;
        m_owner = g;
        m_last  = g;
      end else begin
        m_owner = -1;
        m_cnt   = 0;
      end
    end
    exp_g = g;
    #1;
    check_eq("rvalid0", rvalid0, exp_rv[0]);
    check_eq("rvalid1", rvalid1, exp_rv[1]);
    check_eq("rdata0", rdata0, exp_rd[0]);
    check_eq("rdata1", rdata1, exp_rd[1]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_eq("rst_rvalid0", rvalid0, 1'b0);
    check_eq("rst_rdata1", rdata1, 32'h0);
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    int waited, l;
    logic got0;
    int wait_cnt [2];
    for (int p = 0; p < 2; p++) set_port(p, 1'b0, 1'b0, '0, '0);
    reset   = 1'b1;
    mem_clr = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    @(posedge clk);
    #1;
    mem_clr = 1'b0;
    do_reset();

    // Single master read after reset.
    set_port(0, 1'b1, 1'b0, 14'h0005, '0);
    cycle();
    check_eq("tp1_gnt", obs_g, 0);
    check_eq("tp1_rvalid", rvalid0, 1'b1);
    check_eq("tp1_rdata", rdata0, 32'h1111_FFFF);
    t_req[0] = 1'b0;
    cycle();

    // Tie after reset: 4 beats each, alternating.
    do_reset();
    set_port(0, 1'b1, 1'b0, 14'($urandom_range(0, 63)), '0);
    set_port(1, 1'b1, 1'b0, 14'($urandom_range(0, 63)), '0);
    for (int i = 0; i < 16; i++) begin
      cycle();
      check_eq("tie_seq", obs_g, ((i / 4) % 2 == 0) ? 0 : 1);
      if (exp_g >= 0) t_addr[exp_g] = 14'($urandom_range(0, 63));
    end

    // Lone burst saturates; a late requester is admitted within MAX_BURST.
    t_req[0] = 1'b0;
    set_port(1, 1'b1, 1'b0, 14'h0100, '0);
    waited = 0;
    got0   = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 6) set_port(0, 1'b1, 1'b0, 14'h0007, '0);
      cycle();
      if (i < 6) check_eq("burst_solo", obs_g, 1);
      if (i >= 6 && !got0) begin
        if (obs_g == 0) begin
          got0     = 1'b1;
          t_req[0] = 1'b0;
        end else begin
          waited++;
        end
      end
      if (exp_g == 1) t_addr[1] = t_addr[1] + 14'd1;
    end
    check_eq("burst_wait_ok", got0 && (waited <= MAX_BURST), 1'b1);
    t_req[1] = 1'b0;
    cycle();

    // Write through port 1, read back on port 0, then read-before-write.
    set_port(1, 1'b1, 1'b1, 14'h000C, 32'hABCD_1234);
    cycle();
    set_port(1, 1'b0, 1'b0, '0, '0);
    set_port(0, 1'b1, 1'b0, 14'h000C, '0);
    cycle();
    check_eq("wr_rd_data", rdata0, 32'hABCD_1234);
    t_req[0] = 1'b0;
    set_port(1, 1'b1, 1'b1, 14'h000C, 32'h4321_FFAA);
    cycle();
    check_eq("rbw_old", rdata0, 32'hABCD_1234);
    t_req[1] = 1'b0;
    set_port(0, 1'b1, 1'b0, 14'h000C, '0);
    cycle();
    check_eq("rbw_new", rdata0, 32'h4321_FFAA);
    t_req[0] = 1'b0;

    // Reset in the middle of a port-1 write burst.
    set_port(1, 1'b1, 1'b1, 14'h0020, $urandom);
    for (int i = 0; i < 2; i++) begin
      cycle();
      t_addr[1] = t_addr[1] + 14'd1;
      t_wd[1]   = $urandom;
    end
    reset = 1'b1;
    model_reset();
    #1;
    check_eq("rst_mid_gnt1", gnt1, 1'b0);
    check_eq("rst_mid_we", mem_we, 1'b0);
    check_eq("rst_mid_rvalid0", rvalid0, 1'b0);
    check_eq("rst_mid_rvalid1", rvalid1, 1'b0);
    cycle();
    reset = 1'b0;
    set_port(0, 1'b1, 1'b0, 14'h0022, '0);
    cycle();
    check_eq("rst_tie_gnt0", obs_g, 0);
    check_eq("rst_mem_kept", rdata0, init_word(34));
    for (int i = 0; i < 3; i++) cycle();

    // Idle gap returns to IDLE; next tie goes to the other port.
    l = exp_g;
    t_req[0] = 1'b0;
    t_req[1] = 1'b0;
    cycle();
    check_eq("gap_none", obs_g, -1);
    set_port(0, 1'b1, 1'b0, 14'h0030, '0);
    set_port(1, 1'b1, 1'b0, 14'h0031, '0);
    cycle();
    check_eq("gap_tie", obs_g, 1 - l);

    // Random traffic with a hold-until-granted requester protocol.
    wait_cnt[0] = 0;
    wait_cnt[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!t_req[p] || exp_g == p) begin
          set_port(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                   14'($urandom_range(0, 31)), $urandom);
          wait_cnt[p] = 0;
        end
      end
      cycle();
      for (int p = 0; p < 2; p++) begin
        if (t_req[p] && exp_g != p) wait_cnt[p]++;
        if (exp_g == p) check_eq("max_wait", wait_cnt[p] <= MAX_BURST, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
